// File: rtl/wave_stream_engine.sv
// Explicit-Euler Schrodinger stepper on a MESH_X x MESH_Y lattice with two psi banks.
// One site is updated per clock, and each frame runs n_steps sweeps followed by a bank swap.
module wave_stream_engine #(
    parameter int MESH_X   = 8,
    parameter int MESH_Y   = 8,
    parameter int PSI_W    = 16,
    parameter int V_W      = 16,
    parameter int V_FRAC   = 8,
    parameter int DT_W     = 16,
    parameter int DT_FRAC  = 8,
    parameter int BOUNDARY = 0
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             start,
    input  logic                                             abort,
    input  logic [15:0]                                      n_steps,
    input  logic [DT_W-1:0]                                  dt,
    input  logic                                             pot_we,
    input  logic                                             psi_we,
    input  logic [$clog2(MESH_X)-1:0]                        wr_x,
    input  logic [$clog2(MESH_Y)-1:0]                        wr_y,
    input  logic signed [V_W-1:0]                            wr_pot,
    input  logic signed [PSI_W-1:0]                          wr_re,
    input  logic signed [PSI_W-1:0]                          wr_im,
    input  logic [$clog2(MESH_X)-1:0]                        rd_x,
    input  logic [$clog2(MESH_Y)-1:0]                        rd_y,
    output logic signed [PSI_W-1:0]                          rd_re,
    output logic signed [PSI_W-1:0]                          rd_im,
    output logic [2*PSI_W:0]                                 rd_mag,
    output logic                                             busy,
    output logic                                             step_done,
    output logic                                             frame_done,
    output logic [2*PSI_W+$clog2(MESH_X*MESH_Y):0]           norm_sq,
    output logic                                             sat
);

    localparam int XW  = $clog2(MESH_X);
    localparam int YW  = $clog2(MESH_Y);
    localparam int AW  = XW + YW;
    localparam int NS  = MESH_X * MESH_Y;
    localparam int HW  = PSI_W + V_W + 2;
    localparam int PW  = HW + DT_W + 2;
    localparam int MW  = 2 * PSI_W + 1;
    localparam int NW  = MW + $clog2(NS);
    localparam int SQW = 2 * PSI_W;

    localparam logic signed [PW-1:0] PMAX = {{(PW-PSI_W+1){1'b0}}, {(PSI_W-1){1'b1}}};
    localparam logic signed [PW-1:0] PMIN = {{(PW-PSI_W+1){1'b1}}, {(PSI_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_SWAP} state_t;

    logic signed [PSI_W-1:0] psi_re [2][NS];
    logic signed [PSI_W-1:0] psi_im [2][NS];
    logic signed [V_W-1:0]   pot    [NS];

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [15:0]       steps_q, steps_d;
    logic [DT_W-1:0]   dt_q, dt_d;
    logic              bank_q, bank_d;
    logic [NW-1:0]     acc_q, acc_d;
    logic [NW-1:0]     norm_q, norm_d;
    logic              sat_q, sat_d;
    logic              step_done_q, step_done_d;
    logic              frame_done_q, frame_done_d;
    logic signed [PSI_W-1:0] rd_re_q, rd_re_d, rd_im_q, rd_im_d;
    logic [MW-1:0]     rd_mag_q, rd_mag_d;

    function automatic logic [MW-1:0] mag(input logic signed [PSI_W-1:0] r,
                                          input logic signed [PSI_W-1:0] i);
        logic signed [SQW-1:0] r2, i2;
        r2 = SQW'(r) * SQW'(r);
        i2 = SQW'(i) * SQW'(i);
        return MW'($unsigned(r2)) + MW'($unsigned(i2));
    endfunction

    // Toroidal mode reads the wrapped address directly; the other modes override at edges.
    function automatic logic signed [HW-1:0] nb(input logic edge_f,
                                                input logic signed [PSI_W-1:0] far,
                                                input logic signed [PSI_W-1:0] ctr);
        if (!edge_f || BOUNDARY == 1) return HW'(far);
        else if (BOUNDARY == 2)       return HW'(ctr);
        else                          return '0;
    endfunction

    logic [XW-1:0] cx, xe, xw;
    logic [YW-1:0] cy, yn, ys;
    logic          e_n, e_s, e_e, e_w;
    logic signed [HW-1:0] c_re, c_im, n_re, n_im, s_re, s_im, e_re, e_im, w_re, w_im;
    logic signed [HW-1:0] lap_re, lap_im, vv, hr, hi;
    logic signed [PW-1:0] dts, re_w, im_w;
    logic signed [PSI_W-1:0] clip_re, clip_im;
    logic          clip_hit;
    logic [MW-1:0] new_mag;
    logic          wr_ok, sweep_we;

    always_comb begin
        cx  = idx_q[XW-1:0];
        cy  = idx_q[AW-1:XW];
        xe  = cx + XW'(1);
        xw  = cx - XW'(1);
        yn  = cy + YW'(1);
        ys  = cy - YW'(1);
        e_n = (cy == YW'(MESH_Y - 1));
        e_s = (cy == '0);
        e_e = (cx == XW'(MESH_X - 1));
        e_w = (cx == '0);

        c_re = HW'(psi_re[bank_q][idx_q]);
        c_im = HW'(psi_im[bank_q][idx_q]);
        n_re = nb(e_n, psi_re[bank_q][{yn, cx}], psi_re[bank_q][idx_q]);
        n_im = nb(e_n, psi_im[bank_q][{yn, cx}], psi_im[bank_q][idx_q]);
        s_re = nb(e_s, psi_re[bank_q][{ys, cx}], psi_re[bank_q][idx_q]);
        s_im = nb(e_s, psi_im[bank_q][{ys, cx}], psi_im[bank_q][idx_q]);
        e_re = nb(e_e, psi_re[bank_q][{cy, xe}], psi_re[bank_q][idx_q]);
        e_im = nb(e_e, psi_im[bank_q][{cy, xe}], psi_im[bank_q][idx_q]);
        w_re = nb(e_w, psi_re[bank_q][{cy, xw}], psi_re[bank_q][idx_q]);
        w_im = nb(e_w, psi_im[bank_q][{cy, xw}], psi_im[bank_q][idx_q]);

        lap_re = n_re + s_re + e_re + w_re - (c_re <<< 2);
        lap_im = n_im + s_im + e_im + w_im - (c_im <<< 2);
        vv     = HW'(pot[idx_q]);
        hr     = -(lap_re >>> 1) + ((vv * c_re) >>> V_FRAC);
        hi     = -(lap_im >>> 1) + ((vv * c_im) >>> V_FRAC);

        dts  = PW'($signed({1'b0, dt_q}));
        re_w = PW'(c_re) + ((dts * PW'(hi)) >>> DT_FRAC);
        im_w = PW'(c_im) - ((dts * PW'(hr)) >>> DT_FRAC);

        clip_hit = 1'b0;
        if (re_w > PMAX)      begin clip_re = PMAX[PSI_W-1:0]; clip_hit = 1'b1; end
        else if (re_w < PMIN) begin clip_re = PMIN[PSI_W-1:0]; clip_hit = 1'b1; end
        else                        clip_re = re_w[PSI_W-1:0];
        if (im_w > PMAX)      begin clip_im = PMAX[PSI_W-1:0]; clip_hit = 1'b1; end
        else if (im_w < PMIN) begin clip_im = PMIN[PSI_W-1:0]; clip_hit = 1'b1; end
        else                        clip_im = im_w[PSI_W-1:0];
        new_mag = mag(clip_re, clip_im);
    end

    assign wr_ok    = rst_n && (state_q == S_IDLE) && !(start && !abort);
    assign sweep_we = rst_n && (state_q == S_SWEEP) && !abort;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (psi_we) begin
                psi_re[0][{wr_y, wr_x}] <= wr_re;
                psi_im[0][{wr_y, wr_x}] <= wr_im;
                psi_re[1][{wr_y, wr_x}] <= wr_re;
                psi_im[1][{wr_y, wr_x}] <= wr_im;
            end
            if (pot_we) pot[{wr_y, wr_x}] <= wr_pot;
        end
        if (sweep_we) begin
            psi_re[~bank_q][idx_q] <= clip_re;
            psi_im[~bank_q][idx_q] <= clip_im;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        steps_d      = steps_q;
        dt_d         = dt_q;
        bank_d       = bank_q;
        acc_d        = acc_q;
        norm_d       = norm_q;
        sat_d        = sat_q;
        step_done_d  = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    sat_d   = 1'b0;
                    dt_d    = dt;
                    steps_d = n_steps;
                    idx_d   = '0;
                    acc_d   = '0;
                    if (n_steps == 16'd0) frame_done_d = 1'b1;
                    else                  state_d      = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (abort) state_d = S_IDLE;
                else begin
                    acc_d = acc_q + NW'(new_mag);
                    if (clip_hit) sat_d = 1'b1;
                    if (idx_q == AW'(NS - 1)) state_d = S_SWAP;
                    else                      idx_d   = idx_q + AW'(1);
                end
            end
            S_SWAP: begin
                if (abort) state_d = S_IDLE;
                else begin
                    bank_d      = ~bank_q;
                    norm_d      = acc_q;
                    step_done_d = 1'b1;
                    acc_d       = '0;
                    idx_d       = '0;
                    steps_d     = steps_q - 16'd1;
                    if (steps_q == 16'd1) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = S_SWEEP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_re_d  = psi_re[bank_q][{rd_y, rd_x}];
        rd_im_d  = psi_im[bank_q][{rd_y, rd_x}];
        rd_mag_d = mag(rd_re_d, rd_im_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            steps_q      <= '0;
            dt_q         <= '0;
            bank_q       <= 1'b0;
            acc_q        <= '0;
            norm_q       <= '0;
            sat_q        <= 1'b0;
            step_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            rd_re_q      <= '0;
            rd_im_q      <= '0;
            rd_mag_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            steps_q      <= steps_d;
            dt_q         <= dt_d;
            bank_q       <= bank_d;
            acc_q        <= acc_d;
            norm_q       <= norm_d;
            sat_q        <= sat_d;
            step_done_q  <= step_done_d;
            frame_done_q <= frame_done_d;
            rd_re_q      <= rd_re_d;
            rd_im_q      <= rd_im_d;
            rd_mag_q     <= rd_mag_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign step_done  = step_done_q;
    assign frame_done = frame_done_q;
    assign norm_sq    = norm_q;
    assign sat        = sat_q;
    assign rd_re      = rd_re_q;
    assign rd_im      = rd_im_q;
    assign rd_mag     = rd_mag_q;

endmodule

// File: tb/tb_wave_stream_engine.sv
// Directed bench: three 4x4 engines (absorbing, toroidal, reflecting) share one stimulus stream.
module tb_wave_stream_engine;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, pot_we, psi_we;
    logic [15:0] n_steps, dt;
    logic [1:0]  wr_x, wr_y, rd_x, rd_y;
    logic signed [15:0] wr_pot, wr_re, wr_im;

    logic signed [15:0] rre [3];
    logic signed [15:0] rim [3];
    logic [32:0] rmag [3];
    logic [36:0] nrm [3];
    logic        bsy [3];
    logic        sdn [3];
    logic        fdn [3];
    logic        sto [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wave_stream_engine #(
            .MESH_X(4), .MESH_Y(4), .PSI_W(16), .V_W(16), .V_FRAC(8),
            .DT_W(16), .DT_FRAC(8), .BOUNDARY(g)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
            .n_steps(n_steps), .dt(dt), .pot_we(pot_we), .psi_we(psi_we),
            .wr_x(wr_x), .wr_y(wr_y), .wr_pot(wr_pot), .wr_re(wr_re), .wr_im(wr_im),
            .rd_x(rd_x), .rd_y(rd_y), .rd_re(rre[g]), .rd_im(rim[g]), .rd_mag(rmag[g]),
            .busy(bsy[g]), .step_done(sdn[g]), .frame_done(fdn[g]),
            .norm_sq(nrm[g]), .sat(sto[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int x, input int y, input int re, input int im, input int v, input bit wpot);
        wr_x = 2'(x); wr_y = 2'(y);
        wr_re = 16'(re); wr_im = 16'(im); wr_pot = 16'(v);
        psi_we = 1'b1; pot_we = wpot;
        tick();
        psi_we = 1'b0; pot_we = 1'b0;
    endtask

    task automatic fill(input int x0, input int y0, input int re, input int im);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                if (x == x0 && y == y0) wr(x, y, re, im, 0, 1'b1);
                else                    wr(x, y, 0, 0, 0, 1'b1);
    endtask

    task automatic rdchk(input int d, input int x, input int y, input int er, input int ei, input string tag);
        rd_x = 2'(x); rd_y = 2'(y);
        tick();
        chk({tag, ".re"}, rre[d], er);
        chk({tag, ".im"}, rim[d], ei);
    endtask

    task automatic run_frame(input int steps, input int exp_cycles);
        int c  = 0;
        int sd = 0;
        bit done = 1'b0;
        n_steps = 16'(steps);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", bsy[0], 1);
        while (!done && c < 2000) begin
            tick();
            c++;
            if (sdn[0]) sd++;
            if (fdn[0]) done = 1'b1;
        end
        chk("frame_len", c, exp_cycles);
        chk("step_pulses", sd, steps);
        chk("busy_at_frame_done", bsy[0], 0);
    endtask

    initial begin
        int sd_cnt, fd_cnt, bz_cnt;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pot_we = 1'b0; psi_we = 1'b0;
        n_steps = '0; dt = 16'd256; wr_x = '0; wr_y = '0; rd_x = '0; rd_y = '0;
        wr_pot = '0; wr_re = '0; wr_im = '0;
        repeat (3) tick();
        chk("rst.busy", bsy[0], 0);
        chk("rst.step_done", sdn[0], 0);
        chk("rst.frame_done", fdn[0], 0);
        chk("rst.sat", sto[0], 0);
        chk("rst.norm", nrm[0], 0);
        chk("rst.rd_re", rre[0], 0);
        chk("rst.rd_im", rim[0], 0);
        chk("rst.rd_mag", rmag[0], 0);
        rst_n = 1'b1;
        tick();

        // All-zero field: 3 steps of 17 cycles each
        fill(0, 0, 0, 0);
        run_frame(3, 51);
        chk("zero.norm", nrm[0], 0);
        rdchk(0, 0, 0, 0, 0, "zero.p00");
        rdchk(0, 3, 2, 0, 0, "zero.p32");

        // Single interior spike
        wr(1, 1, 256, 0, 0, 1'b1);
        run_frame(1, 17);
        rdchk(0, 1, 1, 256, -512, "spike.c");
        chk("spike.mag", rmag[0], 327680);
        rdchk(0, 0, 1, 0, 128, "spike.w");
        rdchk(0, 2, 1, 0, 128, "spike.e");
        rdchk(0, 1, 0, 0, 128, "spike.s");
        rdchk(0, 1, 2, 0, 128, "spike.n");
        rdchk(0, 3, 3, 0, 0, "spike.far");
        rdchk(1, 1, 1, 256, -512, "spike.tor.c");
        rdchk(2, 1, 1, 256, -512, "spike.ref.c");
        for (int d = 0; d < 3; d++) chk("spike.norm", nrm[d], 393216);

        // Corner spike under each boundary mode
        fill(0, 0, 256, 0);
        run_frame(1, 17);
        rdchk(0, 3, 0, 0, 0, "abs.p30");
        rdchk(0, 0, 3, 0, 0, "abs.p03");
        rdchk(0, 0, 0, 256, -512, "abs.p00");
        rdchk(1, 3, 0, 0, 128, "tor.p30");
        rdchk(1, 0, 3, 0, 128, "tor.p03");
        rdchk(2, 0, 0, 256, -256, "ref.p00");
        rdchk(2, 1, 0, 0, 128, "ref.p10");
        chk("abs.norm", nrm[0], 360448);
        chk("tor.norm", nrm[1], 393216);
        chk("ref.norm", nrm[2], 163840);

        // Saturation, then sat cleared by a zero-step start
        fill(0, 0, 0, 0);
        wr(2, 2, 32767, 0, 32767, 1'b1);
        run_frame(1, 17);
        rdchk(0, 2, 2, 32767, -32768, "sat.c");
        chk("sat.flag", sto[0], 1);
        n_steps = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zstep.frame_done", fdn[0], 1);
        chk("zstep.busy", bsy[0], 0);
        chk("zstep.sat_clear", sto[0], 0);
        tick();
        chk("zstep.pulse_end", fdn[0], 0);
        wr(2, 2, 0, 0, 0, 1'b1);

        // Abort mid-sweep with a stray start and psi write while busy
        fill(1, 1, 100, -50);
        rdchk(0, 1, 1, 100, -50, "pre.c");
        n_steps = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abt.busy", bsy[0], 1);
        tick();
        tick();
        start = 1'b1; psi_we = 1'b1; wr_x = 2'd1; wr_y = 2'd1; wr_re = 16'sd7; wr_im = 16'sd7;
        tick();
        start = 1'b0; psi_we = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt.busy_drop", bsy[0], 0);
        chk("abt.frame_done", fdn[0], 0);
        chk("abt.step_done", sdn[0], 0);
        sd_cnt = 0; fd_cnt = 0; bz_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (sdn[0]) sd_cnt++;
            if (fdn[0]) fd_cnt++;
            if (bsy[0]) bz_cnt++;
        end
        chk("abt.late_step", sd_cnt, 0);
        chk("abt.late_frame", fd_cnt, 0);
        chk("abt.late_busy", bz_cnt, 0);
        rdchk(0, 1, 1, 100, -50, "abt.c");
        chk("abt.mag", rmag[0], 12500);
        rdchk(0, 1, 0, 0, 0, "abt.p10");

        // Reset mid-frame
        rd_x = 2'd1; rd_y = 2'd1;
        n_steps = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("mid.busy_before", bsy[0], 1);
        rst_n = 1'b0;
        tick();
        chk("mrst.busy", bsy[0], 0);
        chk("mrst.step_done", sdn[0], 0);
        chk("mrst.frame_done", fdn[0], 0);
        chk("mrst.sat", sto[0], 0);
        chk("mrst.norm", nrm[0], 0);
        chk("mrst.rd_re", rre[0], 0);
        chk("mrst.rd_im", rim[0], 0);
        chk("mrst.rd_mag", rmag[0], 0);
        rst_n = 1'b1;
        rdchk(0, 1, 1, 100, -50, "mrst.c");
        rdchk(0, 1, 0, 0, 0, "mrst.p10");
        fd_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (fdn[0] || bsy[0]) fd_cnt++;
        end
        chk("mrst.quiet", fd_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_stream_engine.md
WAVE_STREAM_ENGINE -- requirements
Module: wave_stream_engine

Interface
REQ-001 SHALL have parameter MESH_X, default 8, meaning lattice width in sites (power of two, at least 2).
REQ-002 SHALL have parameter MESH_Y, default 8, meaning lattice height in sites (power of two, at least 2).
REQ-003 SHALL have parameter PSI_W, default 16, meaning width of each signed component of psi (re, im).
REQ-004 SHALL have parameter V_W, default 16, meaning width of the signed potential, with V_FRAC (default 8) fractional bits.
REQ-005 SHALL have parameter DT_W, default 16, meaning width of the unsigned dt, with DT_FRAC (default 8) fractional bits.
REQ-006 SHALL have parameter BOUNDARY, default 0, meaning boundary mode: 0 absorbing, 1 toroidal, 2 reflecting.
REQ-007 SHALL have ports, in order:
- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  starts a frame.
- abort  in  1  cancels a frame.
- n_steps  in  16  steps per frame, sampled at start.
- dt  in  DT_W  time step, sampled at start.
- pot_we  in  1  potential write strobe.
- psi_we  in  1  psi write strobe.
- wr_x / wr_y  in  clog2(MESH_X) / clog2(MESH_Y)  write address.
- wr_pot  in  V_W  potential data.
- wr_re / wr_im  in  PSI_W  psi data.
- rd_x / rd_y  in  address widths  readout address.
- rd_re / rd_im  out  PSI_W  registered active-bank psi.
- rd_mag  out  2*PSI_W+1  registered re^2+im^2.
- busy  out  1  frame in progress.
- step_done  out  1  one-cycle pulse per completed step.
- frame_done  out  1  one-cycle pulse per completed frame.
- norm_sq  out  2*PSI_W+1+clog2(MESH_X*MESH_Y)  sum of |psi|^2 for the last completed step.
- sat  out  1  sticky saturation flag.

Function
REQ-008 SHALL hold psi in two banks (A, B) and V in one array; bank_sel selects the active (read) bank; updates go to the other bank.
REQ-009 SHALL use the FSM IDLE -> SWEEP -> SWAP -> (SWEEP or IDLE); start is accepted only in IDLE.
REQ-010 SHALL, when start is accepted with n_steps=0, pulse frame_done on the next cycle with no psi change and busy remaining low.
REQ-011 SHALL spend exactly MESH_X*MESH_Y cycles in SWEEP, visiting one site per cycle in row-major order (y outer, x inner).
REQ-012 SHALL spend exactly 1 cycle in SWAP, toggling bank_sel, latching norm_sq and pulsing step_done.
REQ-013 SHALL assert busy from the cycle after start through the final SWAP, so a frame lasts n_steps*(MESH_X*MESH_Y+1) cycles; frame_done pulses in the cycle after the final SWAP, the same cycle busy falls.
REQ-014 SHALL compute each site's neighbours N(y+1), S(y-1), E(x+1), W(x-1) from the active bank; out-of-range neighbours are 0 (absorbing), wrapped modulo (toroidal), or replaced by the centre value C (reflecting).
REQ-015 SHALL compute, per component, L = N+S+E+W-4C, Hr = -(L.re>>>1) + ((V*C.re)>>>V_FRAC), and Hi = -(L.im>>>1) + ((V*C.im)>>>V_FRAC), with no intermediate truncation.
REQ-016 SHALL write re' = C.re + ((dt*Hi)>>>DT_FRAC) and im' = C.im - ((dt*Hr)>>>DT_FRAC), each saturated to the signed PSI_W range; any clamp sets sat.
REQ-017 SHALL accumulate re'^2+im'^2 over the sweep, without overflow at the declared width.
REQ-018 SHALL clear sat when start is accepted.
REQ-019 SHALL, on abort during SWEEP or SWAP, return to IDLE next cycle without toggling bank_sel, pulse neither step_done nor frame_done, and drop busy; abort in IDLE has no effect.
REQ-020 SHALL perform pot_we and psi_we writes only in IDLE, ignoring them when busy; psi_we writes both banks.
REQ-021 SHALL give start priority below abort when both are asserted, and give write strobes priority below start in the same cycle (the write is ignored).
REQ-022 SHALL register rd_re, rd_im and rd_mag one cycle after rd_x/rd_y, always from the active bank.

Reset
REQ-023 SHALL, when rst_n=0 at a clk edge, set the FSM to IDLE, bank_sel to A, busy/step_done/frame_done/sat to 0, norm_sq to 0, and rd_* to 0.
REQ-024 SHALL leave psi and V array contents unchanged by reset; reset mid-frame behaves as abort plus the REQ-023 reset values.

Verification (MESH 4x4, PSI_W=16, V_FRAC=DT_FRAC=8)
REQ-025 SHALL cover: all psi=0, V=0, n_steps=3 -> frame_done 51 cycles after start, three step_done pulses, all psi 0, norm_sq 0.
REQ-026 SHALL cover: psi(1,1)=(256,0), others 0, V=0, dt=256, n_steps=1, absorbing -> (1,1)=(256,-512); (0,1),(2,1),(1,0),(1,2)=(0,128).
REQ-027 SHALL cover: psi(0,0)=(256,0), dt=256, V=0 -> toroidal: (3,0) and (0,3)=(0,128); absorbing: (3,0) and (0,3)=(0,0); reflecting: (0,0)=(256,-256).
REQ-028 SHALL cover: psi(2,2)=(32767,0), V(2,2)=32767, dt=256 -> (2,2).im=-32768 and sat=1; sat=0 after the next start.
REQ-029 SHALL cover: abort 5 cycles into the sweep, plus start pulsed while busy -> the start is ignored, bank_sel is unchanged, readout equals the pre-frame values, and no frame_done is pulsed.
REQ-030 SHALL cover: rst_n low mid-frame -> all outputs take their REQ-023 values, and psi readout from bank A shows the unchanged bank A contents.
